adc_capture: RTL and testbench
==============================

# adc_capture

Receive-side counterpart of the DAC output path: drives the clock and output enables of the dual-channel 14-bit ADC and registers both channels. It converts offset-binary codes to two's complement and optionally boxcar-averages 2^AVG_LOG2 samples. It emits per-channel samples tagged with their position within the excitation period. Capture starts from the DAC path's settled-data strobe, so ADC samples stay phase-locked to the generated waveform for the downstream lock-in stages.

## Interface
Parameters:
- ADC_LATENCY, 7: converter pipeline delay in CLK_65 cycles, waited in ALIGN.
- AVG_LOG2, 0: log2 of samples averaged per output; legal range 0..8.

Ports:
- CLK_65  in  1  system/sample clock, 65 MHz. All logic is on its rising edge.
- reset_n  in  1  reset, synchronous, active-low. Clock CLK_65.
- enable  in  1  capture enable; low forces IDLE on the next edge.
- sync_in  in  1  settled-DAC-data strobe from the DAC path; held high while generation is running.
- ptos_x_ciclo  in  16  samples per excitation period (output-sample units).
- ADC_DA, ADC_DB  in  14  ADC channel A/B data, offset binary.
- ADC_OTR_A, ADC_OTR_B  in  1  ADC over-range flags.
- ADC_CLK_A, ADC_CLK_B  out  1  ADC sample clocks; equal to CLK_65.
- ADC_OEB_A, ADC_OEB_B  out  1  ADC output enables, active-low; constant 0.
- data_a, data_b  out  14  signed channel samples or averages.
- data_valid  out  1  one-cycle strobe qualifying data_a, data_b and sample_index.
- sample_index  out  16  position of the current output within the period, 0..P-1.
- cycle_start  out  1  high with data_valid when sample_index == 0.
- ovr_a, ovr_b  out  1  sticky over-range flags.
- capturing  out  1  high while in RUN.

## Operation
- Input stage:
  - ADC_DA, ADC_DB, ADC_OTR_A and ADC_OTR_B are registered unconditionally every cycle.
  - Conversion: s = {~d[13], d[12:0]}. Code 8192 maps to 0, 0 maps to -8192, 16383 maps to +8191.
- FSM, states IDLE / ALIGN / RUN:
  - IDLE → ALIGN when enable && sync_in.
  - ALIGN → RUN after ADC_LATENCY cycles in ALIGN, measured by a counter cleared on entry.
  - ALIGN or RUN → IDLE when !enable, or when sync_in is low for any cycle.
  - Entering ALIGN does the following:
    - latches P = max(ptos_x_ciclo, 1);
    - clears the accumulators, the accumulation counter and sample_index;
    - clears ovr_a and ovr_b.
- RUN, accumulation:
  - Each cycle, the converted sample is added to a signed (14+AVG_LOG2)-bit accumulator per channel.
  - After 2^AVG_LOG2 samples, data_x = acc >>> AVG_LOG2 (arithmetic shift, truncation toward -inf).
  - At the same point data_valid pulses and the accumulator restarts with the current sample. There is no dropped sample.
  - With AVG_LOG2 = 0, data_valid is high every RUN cycle after the pipeline fills.
- Indexing:
  - sample_index advances after each data_valid and wraps P-1 → 0.
  - With P = 1, the index stays 0 and cycle_start accompanies every valid.
  - ptos_x_ciclo changes during RUN are ignored until the next ALIGN.
- Over-range: ovr_x is set by a registered OTR flag during RUN and holds until the next ALIGN entry or reset.
- Leaving RUN:
  - data_valid and cycle_start drop on the next edge.
  - data_a, data_b and sample_index hold their last values.
  - A partial average is discarded.

## Timing
- Reset: all outputs are 0, except ADC_CLK_x = CLK_65 and ADC_OEB_x = 0. State is IDLE, counters are 0.
- Latency with AVG_LOG2 = 0: pins sampled at edge k appear on data_x with data_valid at edge k+2.
- First data_valid: sync_in rising at edge t gives ALIGN from t+1 and RUN from t+1+ADC_LATENCY. The first valid follows 2^AVG_LOG2 - 1 + 2 cycles after RUN entry.
- With AVG_LOG2 = A, data_valid has period 2^A cycles while in RUN.
- Simultaneous !enable and the averaging boundary: IDLE wins and no valid is issued.
- sync_in re-rising while in IDLE restarts the full ALIGN sequence.
- reset_n low mid-RUN: all outputs take reset values on that edge.

## Test plan
- Reset, then ADC_DA = 16383 and ADC_DB = 0 held, enable = 1, sync_in high at t.
  - Required: capturing goes high at t+8 (ADC_LATENCY = 7).
  - Required: the first data_valid has data_a = 8191 and data_b = -8192.
- Ramp ADC_DA = n, AVG_LOG2 = 0.
  - Required: data_a equals the converted pin value from 2 cycles earlier.
  - Required: data_valid is continuous.
- AVG_LOG2 = 2, ADC_DA cycling 8192, 8196, 8200, 8204.
  - Required: data_valid every 4 cycles with data_a = 6.
  - Required: a repeated -1 input code pattern rounds toward -inf.
- ptos_x_ciclo = 5: sample_index runs 0,1,2,3,4,0, with cycle_start on each 0.
  - Change ptos_x_ciclo to 3 mid-RUN: the period stays 5 until sync_in drops and re-rises.
- ADC_OTR_A pulses for 1 cycle in RUN: ovr_a sets and holds; ovr_b stays 0. A new ALIGN clears ovr_a.
- sync_in dropped mid-average (AVG_LOG2 = 3), or reset_n low mid-RUN.
  - Required: no data_valid from the partial average; FSM returns to IDLE.
  - Required after reset: outputs are 0 on the next edge.

Source files
------------

// File: rtl/adc_capture.sv
// adc_capture: clocks the dual 14-bit ADC, converts offset-binary codes to two's complement,
// boxcar-averages 2^AVG_LOG2 samples and tags each output with its position in the excitation period.
module adc_capture #(
  parameter int ADC_LATENCY = 7,
  parameter int AVG_LOG2    = 0
) (
  input  logic               CLK_65,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               sync_in,
  input  logic [15:0]        ptos_x_ciclo,
  input  logic [13:0]        ADC_DA,
  input  logic [13:0]        ADC_DB,
  input  logic               ADC_OTR_A,
  input  logic               ADC_OTR_B,
  output logic               ADC_CLK_A,
  output logic               ADC_CLK_B,
  output logic               ADC_OEB_A,
  output logic               ADC_OEB_B,
  output logic signed [13:0] data_a,
  output logic signed [13:0] data_b,
  output logic               data_valid,
  output logic [15:0]        sample_index,
  output logic               cycle_start,
  output logic               ovr_a,
  output logic               ovr_b,
  output logic               capturing
);
  localparam int AW = 14 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [CW-1:0] AVG_FULL   = CW'(2 ** AVG_LOG2);
  localparam logic [15:0]   ALIGN_LAST = 16'(ADC_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, ALIGN, RUN} state_t;

  state_t                 state;
  logic [13:0]            da_q, db_q;
  logic                   otr_a_q, otr_b_q;
  logic signed [13:0]     s_a, s_b;
  logic signed [AW-1:0]   ext_a, ext_b;
  logic signed [AW-1:0]   acc_a, acc_b;
  logic [CW-1:0]          avg_cnt;
  logic [15:0]            align_cnt;
  logic [15:0]            period;
  logic [15:0]            next_idx;
  logic                   live;

  assign ADC_CLK_A = CLK_65;
  assign ADC_CLK_B = CLK_65;
  assign ADC_OEB_A = 1'b0;
  assign ADC_OEB_B = 1'b0;

  always_ff @(posedge CLK_65) begin
    da_q    <= ADC_DA;
    db_q    <= ADC_DB;
    otr_a_q <= ADC_OTR_A;
    otr_b_q <= ADC_OTR_B;
  end

  // Flipping the MSB turns offset binary into two's complement.
  assign s_a   = {~da_q[13], da_q[12:0]};
  assign s_b   = {~db_q[13], db_q[12:0]};
  assign ext_a = AW'(s_a);
  assign ext_b = AW'(s_b);
  assign live  = enable && sync_in;

  always_ff @(posedge CLK_65) begin
    if (!reset_n) begin
      state        <= IDLE;
      align_cnt    <= '0;
      avg_cnt      <= '0;
      acc_a        <= '0;
      acc_b        <= '0;
      period       <= 16'd1;
      next_idx     <= '0;
      data_a       <= '0;
      data_b       <= '0;
      data_valid   <= 1'b0;
      sample_index <= '0;
      cycle_start  <= 1'b0;
      ovr_a        <= 1'b0;
      ovr_b        <= 1'b0;
      capturing    <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      cycle_start <= 1'b0;
      case (state)
        IDLE: begin
          if (live) begin
            state        <= ALIGN;
            align_cnt    <= '0;
            period       <= (ptos_x_ciclo == 16'd0) ? 16'd1 : ptos_x_ciclo;
            acc_a        <= '0;
            acc_b        <= '0;
            avg_cnt      <= '0;
            next_idx     <= '0;
            sample_index <= '0;
            ovr_a        <= 1'b0;
            ovr_b        <= 1'b0;
          end
        end
        ALIGN: begin
          if (!live) begin
            state <= IDLE;
          end else if (align_cnt == ALIGN_LAST) begin
            state     <= RUN;
            capturing <= 1'b1;
          end else begin
            align_cnt <= align_cnt + 16'd1;
          end
        end
        RUN: begin
          if (!live) begin
            state     <= IDLE;
            capturing <= 1'b0;
          end else begin
            if (otr_a_q) ovr_a <= 1'b1;
            if (otr_b_q) ovr_b <= 1'b1;
            // A full window is emitted while the current sample seeds the next one.
            if (avg_cnt == AVG_FULL) begin
              data_a       <= 14'(acc_a >>> AVG_LOG2);
              data_b       <= 14'(acc_b >>> AVG_LOG2);
              data_valid   <= 1'b1;
              sample_index <= next_idx;
              cycle_start  <= (next_idx == 16'd0);
              next_idx     <= (next_idx == period - 16'd1) ? 16'd0 : next_idx + 16'd1;
              acc_a        <= ext_a;
              acc_b        <= ext_b;
              avg_cnt      <= CW'(1);
            end else begin
              acc_a   <= acc_a + ext_a;
              acc_b   <= acc_b + ext_b;
              avg_cnt <= avg_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: three instances (AVG_LOG2 = 0, 2, 3) share the stimulus and are checked
// every cycle against a window-average model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_adc_capture;
  localparam int LAT = 7;

  logic CLK_65 = 1'b0;
  always #5 CLK_65 = ~CLK_65;

  logic        reset_n, enable, sync_in, otra, otrb;
  logic [15:0] ptos;
  logic [13:0] da, db;

  logic        o_clka [3], o_clkb [3], o_oeba [3], o_oebb [3];
  logic        o_vld [3], o_cs [3], o_ovra [3], o_ovrb [3], o_cap [3];
  logic [13:0] o_da [3], o_db [3];
  logic [15:0] o_idx [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    adc_capture #(.ADC_LATENCY(LAT), .AVG_LOG2(g == 0 ? 0 : (g == 1 ? 2 : 3))) u_dut (
      .CLK_65(CLK_65), .reset_n(reset_n), .enable(enable), .sync_in(sync_in),
      .ptos_x_ciclo(ptos), .ADC_DA(da), .ADC_DB(db), .ADC_OTR_A(otra), .ADC_OTR_B(otrb),
      .ADC_CLK_A(o_clka[g]), .ADC_CLK_B(o_clkb[g]), .ADC_OEB_A(o_oeba[g]), .ADC_OEB_B(o_oebb[g]),
      .data_a(o_da[g]), .data_b(o_db[g]), .data_valid(o_vld[g]), .sample_index(o_idx[g]),
      .cycle_start(o_cs[g]), .ovr_a(o_ovra[g]), .ovr_b(o_ovrb[g]), .capturing(o_cap[g])
    );
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic int avg_of(input int g);
    return (g == 0) ? 0 : ((g == 1) ? 2 : 3);
  endfunction

  function automatic int floor_div(input int s, input int n);
    int q;
    q = s / n;
    if ((s % n) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  // Model: pin history plus phase tracking; outputs are window averages of past pins.
  int cyc = 0;
  int ha [1024], hb [1024];
  bit hoa [1024], hob [1024];
  int m_ph [3], m_start [3], m_p [3];
  int e_vld [3], e_cs [3], e_da [3], e_db [3], e_idx [3], e_ovra [3], e_ovrb [3], e_cap [3];

  always @(posedge CLK_65) begin
    int e, n, k, j, sa, sb;
    bit live;
    cyc = cyc + 1;
    e = cyc;
    ha[e % 1024]  = int'(da) - 8192;
    hb[e % 1024]  = int'(db) - 8192;
    hoa[e % 1024] = otra;
    hob[e % 1024] = otrb;
    live = enable && sync_in;
    for (int g = 0; g < 3; g++) begin
      n = 1 << avg_of(g);
      e_vld[g] = 0;
      e_cs[g]  = 0;
      if (!reset_n) begin
        m_ph[g] = 0; e_da[g] = 0; e_db[g] = 0; e_idx[g] = 0;
        e_ovra[g] = 0; e_ovrb[g] = 0;
      end else if (m_ph[g] == 0) begin
        if (live) begin
          m_ph[g] = 1; m_start[g] = e;
          m_p[g] = (ptos == 16'd0) ? 1 : int'(ptos);
          e_idx[g] = 0; e_ovra[g] = 0; e_ovrb[g] = 0;
        end
      end else if (!live) begin
        m_ph[g] = 0;
      end else if (m_ph[g] == 1) begin
        if (e - m_start[g] == LAT) begin
          m_ph[g] = 2; m_start[g] = e;
        end
      end else begin
        k = e - m_start[g];
        if (hoa[(e - 1) % 1024]) e_ovra[g] = 1;
        if (hob[(e - 1) % 1024]) e_ovrb[g] = 1;
        if (k > n && ((k - 1) % n) == 0) begin
          j = (k - 1) / n - 1;
          sa = 0; sb = 0;
          for (int i = 1; i <= n; i++) begin
            sa += ha[(e - 1 - i) % 1024];
            sb += hb[(e - 1 - i) % 1024];
          end
          e_da[g] = floor_div(sa, n);
          e_db[g] = floor_div(sb, n);
          e_vld[g] = 1;
          e_idx[g] = j % m_p[g];
          e_cs[g]  = (e_idx[g] == 0) ? 1 : 0;
        end
      end
      e_cap[g] = (m_ph[g] == 2) ? 1 : 0;
    end
  end

  always @(negedge CLK_65) begin
    if (cyc > 0) begin
      for (int g = 0; g < 3; g++) begin
        chk($sformatf("data_valid[%0d]@%0d", g, cyc), int'(o_vld[g]), e_vld[g]);
        chk($sformatf("cycle_start[%0d]@%0d", g, cyc), int'(o_cs[g]), e_cs[g]);
        chk($sformatf("data_a[%0d]@%0d", g, cyc), int'($signed(o_da[g])), e_da[g]);
        chk($sformatf("data_b[%0d]@%0d", g, cyc), int'($signed(o_db[g])), e_db[g]);
        chk($sformatf("sample_index[%0d]@%0d", g, cyc), int'(o_idx[g]), e_idx[g]);
        chk($sformatf("ovr_a[%0d]@%0d", g, cyc), int'(o_ovra[g]), e_ovra[g]);
        chk($sformatf("ovr_b[%0d]@%0d", g, cyc), int'(o_ovrb[g]), e_ovrb[g]);
        chk($sformatf("capturing[%0d]@%0d", g, cyc), int'(o_cap[g]), e_cap[g]);
        chk($sformatf("adc_clk[%0d]@%0d", g, cyc), int'(o_clka[g]) + int'(o_clkb[g]), 2 * int'(CLK_65));
        chk($sformatf("adc_oeb[%0d]@%0d", g, cyc), int'(o_oeba[g]) + int'(o_oebb[g]), 0);
      end
    end
  end

  task automatic step();
    @(posedge CLK_65);
    #1;
  endtask

  int t, cap_cyc, found;
  int fv [3], fd_a [3], fd_b [3], lastv [3];
  int idxq [$], csq [$];
  int p5 [6] = '{0, 1, 2, 3, 4, 0};
  int p3 [4] = '{0, 1, 2, 0};

  initial begin
    reset_n = 1'b0; enable = 1'b0; sync_in = 1'b0; ptos = 16'd5;
    da = 14'd16383; db = 14'd0; otra = 1'b0; otrb = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();

    // Start capture: full-scale A, zero-scale B.
    enable = 1'b1; sync_in = 1'b1; t = cyc;
    cap_cyc = -1; fv = '{-1, -1, -1};
    for (int n = 0; n < 30 && fv[2] < 0; n++) begin
      step();
      if (cap_cyc < 0 && o_cap[0]) cap_cyc = cyc;
      for (int g = 0; g < 3; g++)
        if (fv[g] < 0 && o_vld[g]) begin
          fv[g] = cyc; fd_a[g] = int'($signed(o_da[g])); fd_b[g] = int'($signed(o_db[g]));
        end
      if (o_vld[0] && idxq.size() < 6) begin
        idxq.push_back(int'(o_idx[0])); csq.push_back(int'(o_cs[0]));
      end
    end
    chk("capturing_rise_cycle", cap_cyc, t + 8);
    chk("first_valid_cycle_avg0", fv[0], t + 10);
    chk("first_valid_cycle_avg2", fv[1], t + 13);
    chk("first_valid_cycle_avg3", fv[2], t + 17);
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("first_data_a[%0d]", g), fd_a[g], 8191);
      chk($sformatf("first_data_b[%0d]", g), fd_b[g], -8192);
    end
    chk("index_p5_count", idxq.size(), 6);
    for (int i = 0; i < idxq.size(); i++) begin
      chk($sformatf("index_p5[%0d]", i), idxq[i], p5[i]);
      chk($sformatf("cycle_start_p5[%0d]", i), csq[i], (p5[i] == 0) ? 1 : 0);
    end

    // Ramp with a period change that must stay ignored until the next ALIGN.
    ptos = 16'd3;
    for (int i = 0; i < 20; i++) begin
      da = 14'(8192 + i);
      step();
      if (i >= 2) begin
        chk($sformatf("ramp_valid[%0d]", i), int'(o_vld[0]), 1);
        chk($sformatf("ramp_data[%0d]", i), int'($signed(o_da[0])), i - 2);
      end
    end

    lastv = '{-1, -1, -1};
    for (int i = 0; i < 32; i++) begin
      da = 14'(8192 + 4 * (i % 4));
      step();
      if (i >= 12)
        for (int g = 1; g < 3; g++)
          if (o_vld[g]) begin
            chk($sformatf("avg6_data[%0d]@%0d", g, i), int'($signed(o_da[g])), 6);
            if (lastv[g] >= 0)
              chk($sformatf("avg_period[%0d]@%0d", g, i), cyc - lastv[g], 1 << avg_of(g));
            lastv[g] = cyc;
          end
    end

    // One -1 code per four: truncation toward -inf gives -1, not 0.
    for (int i = 0; i < 32; i++) begin
      da = (i % 4 == 0) ? 14'd8191 : 14'd8192;
      step();
      if (i >= 2)
        chk($sformatf("neg_raw[%0d]", i), int'($signed(o_da[0])), ((i - 2) % 4 == 0) ? -1 : 0);
      if (i >= 12)
        for (int g = 1; g < 3; g++)
          if (o_vld[g]) chk($sformatf("neg_avg[%0d]@%0d", g, i), int'($signed(o_da[g])), -1);
    end

    otra = 1'b1;
    step();
    otra = 1'b0;
    chk("ovr_a_not_early", int'(o_ovra[0]), 0);
    step();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("ovr_a_set[%0d]", g), int'(o_ovra[g]), 1);
      chk($sformatf("ovr_b_clear[%0d]", g), int'(o_ovrb[g]), 0);
    end
    repeat (5) step();
    chk("ovr_a_sticky", int'(o_ovra[0]), 1);

    // Re-arm: the new period is latched and ovr is cleared.
    sync_in = 1'b0;
    step();
    chk("capturing_drop", int'(o_cap[0]), 0);
    step();
    sync_in = 1'b1;
    step();
    for (int g = 0; g < 3; g++) chk($sformatf("ovr_a_align_clear[%0d]", g), int'(o_ovra[g]), 0);
    idxq.delete(); csq.delete();
    for (int n = 0; n < 30 && idxq.size() < 4; n++) begin
      step();
      if (o_vld[0]) begin
        idxq.push_back(int'(o_idx[0])); csq.push_back(int'(o_cs[0]));
      end
    end
    chk("index_p3_count", idxq.size(), 4);
    for (int i = 0; i < idxq.size(); i++) begin
      chk($sformatf("index_p3[%0d]", i), idxq[i], p3[i]);
      chk($sformatf("cycle_start_p3[%0d]", i), csq[i], (p3[i] == 0) ? 1 : 0);
    end

    // Drop sync three cycles into an 8-sample window.
    found = 0;
    for (int n = 0; n < 40 && found == 0; n++) begin
      step();
      if (o_vld[2]) found = 1;
    end
    chk("wait_valid_avg3", found, 1);
    repeat (3) step();
    sync_in = 1'b0;
    for (int n = 0; n < 12; n++) begin
      step();
      for (int g = 0; g < 3; g++) chk($sformatf("no_partial_valid[%0d]@%0d", g, n), int'(o_vld[g]), 0);
    end
    for (int g = 0; g < 3; g++) chk($sformatf("idle_after_drop[%0d]", g), int'(o_cap[g]), 0);

    // enable falls on a cycle where a valid would otherwise be issued.
    da = 14'd16000; db = 14'd300; sync_in = 1'b1;
    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      step();
      if (o_cap[0]) found = 1;
    end
    chk("wait_capture_2", found, 1);
    repeat (4) step();
    chk("valid_before_disable", int'(o_vld[0]), 1);
    enable = 1'b0;
    step();
    chk("disable_kills_valid", int'(o_vld[0]), 0);
    chk("disable_to_idle", int'(o_cap[0]), 0);
    chk("data_a_holds", int'($signed(o_da[0])), 7808);
    enable = 1'b1;

    found = 0;
    for (int n = 0; n < 20 && found == 0; n++) begin
      step();
      if (o_cap[0]) found = 1;
    end
    chk("wait_capture_3", found, 1);
    repeat (6) step();
    otrb = 1'b1;
    step();
    otrb = 1'b0;
    repeat (2) step();
    chk("ovr_b_set", int'(o_ovrb[0]), 1);
    reset_n = 1'b0;
    step();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_valid[%0d]", g), int'(o_vld[g]), 0);
      chk($sformatf("rst_cycle_start[%0d]", g), int'(o_cs[g]), 0);
      chk($sformatf("rst_data_a[%0d]", g), int'(o_da[g]), 0);
      chk($sformatf("rst_data_b[%0d]", g), int'(o_db[g]), 0);
      chk($sformatf("rst_index[%0d]", g), int'(o_idx[g]), 0);
      chk($sformatf("rst_ovr[%0d]", g), int'(o_ovra[g]) + int'(o_ovrb[g]), 0);
      chk($sformatf("rst_capturing[%0d]", g), int'(o_cap[g]), 0);
    end
    reset_n = 1'b1; enable = 1'b0; sync_in = 1'b0;
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded its time bound");
    $fatal(1);
  end
endmodule
